sodor_inductive_state_checker: RTL and testbench
================================================

Name: sodor_inductive_state_checker

Overview:
- Sits directly downstream of the 1-stage core's inductive-state source taps.
- Takes architectural-state snapshots from two core copies in the product circuit: copy A (non-delayed) and copy B (delayed).
- Snapshot fields: reg_mem_en, reg_dmiss, if_inst_buffer, reg_interrupt_edge.
- Buffers each copy's snapshots so retirement skew is absorbed, compares aligned pairs under a mask, and raises sticky mismatch/overflow verdicts for the property checker.

Parameters:
- DEPTH, 4, entries per copy FIFO (power of two, 2..16).
- SNAP_W, 35, snapshot width; fixed by package constant, not overridable in practice.
- CMP_MASK, 35'h7_FFFF_FFFF, per-bit compare enable; 0 bits are ignored.

Ports:
- clock  input  1  core clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  arms checking; pushes are ignored while low
- clear  input  1  synchronous flush of FIFOs, counters and sticky flags
- a_valid  input  1  copy A snapshot valid (retire strobe)
- a_snap  input  35  copy A snapshot, packed:
  - [34] reg_mem_en
  - [33] reg_dmiss
  - [32:1] if_inst_buffer
  - [0] reg_interrupt_edge
- b_valid  input  1  copy B snapshot valid
- b_snap  input  35  copy B snapshot, same layout as a_snap
- cmp_valid  output  1  one-cycle pulse: a pair was compared
- cmp_equal  output  1  result of that compare; meaningful only with cmp_valid
- mismatch  output  1  sticky: some compare failed
- overflow  output  1  sticky: push into a full FIFO
- diff_bits  output  35  masked XOR of the first failing pair; held until clear
- cmp_count  output  16  pairs compared; saturates at 16'hFFFF
- state  output  2  FSM state encoding

Behaviour:
- Reset (reset=1 at a clock edge) forces:
  - all outputs 0, both FIFOs empty, state=IDLE.
  - Reset has priority over clear, enable and valids, including mid-operation.
- FSM states: IDLE=0, RUN=1, MISMATCH=2, OVERFLOW=3.
  - IDLE->RUN when enable=1.
  - RUN->MISMATCH on a failing compare.
  - RUN->OVERFLOW on overflow.
  - MISMATCH and OVERFLOW are absorbing; only clear or reset exit them, to IDLE.
  - If overflow and mismatch occur in the same cycle, OVERFLOW wins. Both sticky flags are still set.
- Push rules:
  - In RUN, a_valid pushes a_snap into FIFO A; same for b_valid into FIFO B.
  - No pushes in IDLE, MISMATCH or OVERFLOW.
  - Pushing into a full FIFO drops the entry and sets overflow.
  - Push and pop on a full FIFO in the same cycle is legal and is not an overflow.
- Pop/compare rules:
  - When both FIFOs are non-empty in RUN, both heads pop in that cycle.
  - Registered result, latency 1:
    - cmp_valid=1 next cycle.
    - cmp_equal = ((headA ^ headB) & CMP_MASK) == 0.
  - A push and compare of the same entry cannot happen in one cycle; minimum push-to-cmp_valid is 2 cycles.
  - Compare is skipped if either FIFO is empty.
  - Throughput: one compare per cycle.
- Counters and capture:
  - cmp_count increments with every cmp_valid and saturates at 16'hFFFF.
  - diff_bits is captured only on the first failure; later failures do not update it.
- clear=1:
  - next cycle: FIFOs empty, cmp_count=0, mismatch=0, overflow=0, diff_bits=0, state=IDLE.
  - Any in-flight compare result is discarded; cmp_valid=0.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. full/empty are derived from MSB and index equality.

Decomposition:
- Package sodor_inductive_pkg holds:
  - SNAP_W=35 and the field bit offsets (MEM_EN_BIT=34, DMISS_BIT=33, INST_LSB=1, INST_MSB=32, INTR_BIT=0).
  - The 2-bit state typedef and encodings.
- Sub-module sodor_snapshot_fifo: synchronous FIFO, parameter DEPTH. Ports: push, push_data, pop, head, empty, full, flush. Instantiated twice.

Test Plan:
- Reset mid-stream: 3 entries queued in A, assert reset -> next cycle all outputs 0, state=0; b_valid afterwards is ignored until enable.
- Lockstep equal: enable=1, then on 5 consecutive cycles push identical snaps on A and B (if_inst_buffer=32'h00000013, others 0) -> cmp_valid pulses 5 times, cmp_equal=1, cmp_count=5, state=RUN.
- Skew absorption: A pushes 3 snaps in cycles 1-3; B pushes the same 3 in cycles 4-6 -> compares in cycles 5-7, all equal, no overflow.
- Mismatch capture: A inst 32'h00000013, B inst 32'h00000033 -> cmp_equal=0, mismatch=1, diff_bits=35'h0_0000_0040, state=MISMATCH. A second differing pair is not pushed and diff_bits is unchanged.
- Masked bit: CMP_MASK with bit 33 cleared, A reg_dmiss=1, B reg_dmiss=0 -> cmp_equal=1, mismatch stays 0.
- Overflow: DEPTH=4, A pushes 5 snaps with no B -> overflow=1 on the 5th push, state=OVERFLOW. Then clear=1 -> next cycle everything 0, state=IDLE.

Source files
------------

// File: rtl/sodor_inductive_state_checker_pkg.sv
// -----------------------------------------------------------------------------
// sodor_inductive_pkg
//   Shared constants and types for the inductive-state checker.
//   - SNAP_W and the field offsets of a packed architectural snapshot
//     {reg_mem_en, reg_dmiss, if_inst_buffer[31:0], reg_interrupt_edge}.
//   - Checker FSM state type and its fixed encodings.
//   - masked_diff(): the per-bit compare used on aligned snapshot pairs.
// -----------------------------------------------------------------------------
package sodor_inductive_pkg;

    localparam int SNAP_W     = 35;
    localparam int MEM_EN_BIT = 34;
    localparam int DMISS_BIT  = 33;
    localparam int INST_MSB   = 32;
    localparam int INST_LSB   = 1;
    localparam int INTR_BIT   = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MISMATCH = 2'd2,
        ST_OVERFLOW = 2'd3
    } chk_state_e;

    // Bits set in the result are differences the caller cares about.
    function automatic logic [SNAP_W-1:0] masked_diff(
        input logic [SNAP_W-1:0] a,
        input logic [SNAP_W-1:0] b,
        input logic [SNAP_W-1:0] mask
    );
        return (a ^ b) & mask;
    endfunction

endpackage

// File: rtl/sodor_inductive_state_checker_if.sv
// -----------------------------------------------------------------------------
// sodor_inductive_state_checker_if
//   Snapshot/verdict bundle between the product-circuit taps and the checker.
//   master : drives enable/clear and both snapshot streams, observes verdicts.
//   slave  : the checker side.
//   Inputs to checker : enable, clear, a_valid, a_snap, b_valid, b_snap
//   Outputs of checker: cmp_valid, cmp_equal, mismatch, overflow, diff_bits,
//                       cmp_count[15:0], state[1:0]
// -----------------------------------------------------------------------------
interface sodor_inductive_state_checker_if;
    import sodor_inductive_pkg::*;

    logic              enable;
    logic              clear;
    logic              a_valid;
    logic [SNAP_W-1:0] a_snap;
    logic              b_valid;
    logic [SNAP_W-1:0] b_snap;
    logic              cmp_valid;
    logic              cmp_equal;
    logic              mismatch;
    logic              overflow;
    logic [SNAP_W-1:0] diff_bits;
    logic [15:0]       cmp_count;
    logic [1:0]        state;

    modport master (
        output enable, clear, a_valid, a_snap, b_valid, b_snap,
        input  cmp_valid, cmp_equal, mismatch, overflow, diff_bits, cmp_count, state
    );

    modport slave (
        input  enable, clear, a_valid, a_snap, b_valid, b_snap,
        output cmp_valid, cmp_equal, mismatch, overflow, diff_bits, cmp_count, state
    );

endinterface

// File: rtl/sodor_inductive_state_checker_fifo.sv
// -----------------------------------------------------------------------------
// sodor_snapshot_fifo
//   Synchronous snapshot FIFO, DEPTH entries (power of two).
//   clk_i, rst_i (sync, active high), flush_i (sync empty)
//   push_i/push_data_i : write; dropped when full unless popping same cycle
//   pop_i              : advance head; ignored when empty
//   head_o             : current head entry (valid when !empty_o)
//   empty_o, full_o    : occupancy flags
// -----------------------------------------------------------------------------
module sodor_snapshot_fifo
    import sodor_inductive_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = SNAP_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra pointer bit tells full from empty when the indices match.
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/sodor_inductive_state_checker.sv
// -----------------------------------------------------------------------------
// sodor_inductive_state_checker
//   Buffers architectural snapshots from the non-delayed (A) and delayed (B)
//   core copies, pops aligned pairs, compares them under CMP_MASK and keeps
//   sticky mismatch/overflow verdicts for the property checker.
//   clock, reset : core clock, synchronous active-high reset
//   chk (slave)  : enable/clear, A/B snapshot streams, compare result
//                  (1-cycle latency), sticky flags, first diff, compare count,
//                  FSM state.
// -----------------------------------------------------------------------------
module sodor_inductive_state_checker
    import sodor_inductive_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [SNAP_W-1:0] CMP_MASK = 35'h7_FFFF_FFFF
) (
    input  logic                           clock,
    input  logic                           reset,
    sodor_inductive_state_checker_if.slave chk
);
    chk_state_e        state_q, state_d;
    logic              a_empty, a_full, b_empty, b_full;
    logic [SNAP_W-1:0] a_head, b_head, diff;
    logic              run, pop, push_a, push_b, ovf, fail;

    logic              cmp_valid_q, cmp_valid_d;
    logic              cmp_equal_q, cmp_equal_d;
    logic              mismatch_q, mismatch_d;
    logic              overflow_q, overflow_d;
    logic [SNAP_W-1:0] diff_q, diff_d;
    logic [15:0]       count_q, count_d;

    assign run    = (state_q == ST_RUN);
    // Popping is gated only by RUN and occupancy; enable only gates pushes.
    assign pop    = run && !a_empty && !b_empty;
    assign push_a = run && chk.enable && chk.a_valid;
    assign push_b = run && chk.enable && chk.b_valid;
    assign ovf    = (push_a && a_full && !pop) || (push_b && b_full && !pop);
    assign diff   = masked_diff(a_head, b_head, CMP_MASK);
    assign fail   = pop && (diff != '0);

    sodor_snapshot_fifo #(.DEPTH(DEPTH), .W(SNAP_W)) u_fifo_a (
        .clk_i       (clock),
        .rst_i       (reset),
        .flush_i     (chk.clear),
        .push_i      (push_a),
        .push_data_i (chk.a_snap),
        .pop_i       (pop),
        .head_o      (a_head),
        .empty_o     (a_empty),
        .full_o      (a_full)
    );

    sodor_snapshot_fifo #(.DEPTH(DEPTH), .W(SNAP_W)) u_fifo_b (
        .clk_i       (clock),
        .rst_i       (reset),
        .flush_i     (chk.clear),
        .push_i      (push_b),
        .push_data_i (chk.b_snap),
        .pop_i       (pop),
        .head_o      (b_head),
        .empty_o     (b_empty),
        .full_o      (b_full)
    );

    // FSM next state; overflow outranks mismatch when both hit together.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (chk.enable) state_d = ST_RUN;
            ST_RUN: begin
                if (ovf)       state_d = ST_OVERFLOW;
                else if (fail) state_d = ST_MISMATCH;
            end
            ST_MISMATCH: state_d = ST_MISMATCH;
            ST_OVERFLOW: state_d = ST_OVERFLOW;
            default:     state_d = ST_IDLE;
        endcase
        if (chk.clear) state_d = ST_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Compare result and verdict registers.
    always_comb begin
        cmp_valid_d = pop;
        cmp_equal_d = pop && (diff == '0);
        mismatch_d  = mismatch_q | fail;
        overflow_d  = overflow_q | ovf;
        diff_d      = (fail && !mismatch_q) ? diff : diff_q;
        count_d     = (pop && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;
        if (chk.clear) begin
            // Flush also drops the compare that would have landed next cycle.
            cmp_valid_d = 1'b0;
            cmp_equal_d = 1'b0;
            mismatch_d  = 1'b0;
            overflow_d  = 1'b0;
            diff_d      = '0;
            count_d     = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cmp_valid_q <= 1'b0;
            cmp_equal_q <= 1'b0;
            mismatch_q  <= 1'b0;
            overflow_q  <= 1'b0;
            diff_q      <= '0;
            count_q     <= '0;
        end else begin
            cmp_valid_q <= cmp_valid_d;
            cmp_equal_q <= cmp_equal_d;
            mismatch_q  <= mismatch_d;
            overflow_q  <= overflow_d;
            diff_q      <= diff_d;
            count_q     <= count_d;
        end
    end

    assign chk.cmp_valid = cmp_valid_q;
    assign chk.cmp_equal = cmp_equal_q;
    assign chk.mismatch  = mismatch_q;
    assign chk.overflow  = overflow_q;
    assign chk.diff_bits = diff_q;
    assign chk.cmp_count = count_q;
    assign chk.state     = state_q;

endmodule

// File: tb/tb_sodor_inductive_state_checker.sv
// -----------------------------------------------------------------------------
// tb_sodor_inductive_state_checker
//   Directed scenarios plus randomized traffic against a queue-based model
//   of the checker. The DUT masks out reg_dmiss (bit 33) so masking is seen.
// -----------------------------------------------------------------------------
module tb_sodor_inductive_state_checker;
    localparam int          DEPTH = 4;
    localparam logic [34:0] MASK  = 35'h5_FFFF_FFFF;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sodor_inductive_state_checker_if bus();

    sodor_inductive_state_checker #(.DEPTH(DEPTH), .CMP_MASK(MASK)) dut (
        .clock (clock),
        .reset (reset),
        .chk   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [34:0] qa[$];
    logic [34:0] qb[$];
    int          m_state = 0;   // 0 idle, 1 run, 2 mismatch, 3 overflow
    int          m_cnt   = 0;
    bit          m_cv, m_eq, m_mis, m_ovf;
    logic [34:0] m_diff  = '0;
    logic [34:0] ha, hb, dd;
    bit          bad, ovf_ev;
    bit          model_on = 0;

    always @(posedge clock) begin
        if (reset || bus.clear) begin
            qa.delete(); qb.delete();
            m_state = 0; m_cnt = 0; m_cv = 0; m_eq = 0;
            m_mis = 0; m_ovf = 0; m_diff = '0;
        end else begin
            m_cv = 0; m_eq = 0; bad = 0; ovf_ev = 0;
            if (m_state == 1) begin
                if (qa.size() > 0 && qb.size() > 0) begin
                    ha = qa.pop_front();
                    hb = qb.pop_front();
                    dd = (ha ^ hb) & MASK;
                    m_cv = 1;
                    m_eq = (dd == 0);
                    if (m_cnt < 65535) m_cnt++;
                    if (!m_eq) begin
                        bad = 1;
                        if (!m_mis) m_diff = dd;
                        m_mis = 1;
                    end
                end
                if (bus.enable && bus.a_valid) begin
                    if (qa.size() < DEPTH) qa.push_back(bus.a_snap); else ovf_ev = 1;
                end
                if (bus.enable && bus.b_valid) begin
                    if (qb.size() < DEPTH) qb.push_back(bus.b_snap); else ovf_ev = 1;
                end
                if (ovf_ev) begin
                    m_ovf = 1;
                    m_state = 3;
                end else if (bad) begin
                    m_state = 2;
                end
            end else if (m_state == 0 && bus.enable) begin
                m_state = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int pulses = 0;
    int eq_pulses = 0;
    always @(negedge clock) begin
        if (model_on) begin
            chk("cmp_valid", bus.cmp_valid, m_cv);
            if (m_cv) chk("cmp_equal", bus.cmp_equal, m_eq);
            chk("state", bus.state, m_state);
            chk("mismatch", bus.mismatch, m_mis);
            chk("overflow", bus.overflow, m_ovf);
            chk("diff_bits", bus.diff_bits, m_diff);
            chk("cmp_count", bus.cmp_count, m_cnt);
            if (bus.cmp_valid === 1'b1) begin
                pulses++;
                if (bus.cmp_equal === 1'b1) eq_pulses++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(negedge clock);
        #1;
    endtask

    task automatic push2(input bit av, input logic [34:0] as, input bit bv, input logic [34:0] bs);
        cyc();
        bus.a_valid = av; bus.a_snap = as;
        bus.b_valid = bv; bus.b_snap = bs;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) push2(0, '0, 0, '0);
    endtask

    function automatic logic [34:0] rnd35();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[34:0];
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, ".state"}, bus.state, 0);
        chk({tag, ".cmp_valid"}, bus.cmp_valid, 0);
        chk({tag, ".mismatch"}, bus.mismatch, 0);
        chk({tag, ".overflow"}, bus.overflow, 0);
        chk({tag, ".diff_bits"}, bus.diff_bits, 0);
        chk({tag, ".cmp_count"}, bus.cmp_count, 0);
    endtask

    localparam logic [34:0] INST13 = 35'h0_0000_0026;  // if_inst_buffer=32'h13
    localparam logic [34:0] INST33 = 35'h0_0000_0066;  // if_inst_buffer=32'h33
    localparam logic [34:0] DMISS  = 35'h2_0000_0000;

    logic [34:0] pend[$];
    logic [34:0] s0, s1, s2;

    initial begin
        bus.enable = 0; bus.clear = 0;
        bus.a_valid = 0; bus.a_snap = '0;
        bus.b_valid = 0; bus.b_snap = '0;

        // Reset state
        cyc(); cyc();
        model_on = 1;
        check_zero("reset");
        chk("reset.cmp_equal", bus.cmp_equal, 0);
        reset = 0;

        // Reset mid-stream: 3 entries queued in A, then reset
        bus.enable = 1;
        push2(1, 35'h1_2345_6789, 0, '0);
        push2(1, 35'h0_1111_1111, 0, '0);
        push2(1, 35'h4_0000_0001, 0, '0);
        cyc(); bus.a_valid = 0; reset = 1; bus.enable = 0;
        cyc(); reset = 0;
        check_zero("midreset");
        bus.b_valid = 1; bus.b_snap = 35'h7_0000_0000;
        cyc(); cyc(); bus.b_valid = 0;
        chk("idle_ignores_b.state", bus.state, 0);
        chk("idle_ignores_b.count", bus.cmp_count, 0);

        // Lockstep equal, 5 pairs
        bus.enable = 1;
        cyc();
        pulses = 0; eq_pulses = 0;
        for (int i = 0; i < 5; i++) push2(1, INST13, 1, INST13);
        idle(3);
        chk("lockstep.pulses", pulses, 5);
        chk("lockstep.eq_pulses", eq_pulses, 5);
        chk("lockstep.count", bus.cmp_count, 5);
        chk("lockstep.state", bus.state, 1);

        // Skew absorption: B trails A by three cycles
        s0 = rnd35(); s1 = rnd35(); s2 = rnd35();
        push2(1, s0, 0, '0); push2(1, s1, 0, '0); push2(1, s2, 0, '0);
        push2(0, '0, 1, s0); push2(0, '0, 1, s1); push2(0, '0, 1, s2);
        idle(3);
        chk("skew.count", bus.cmp_count, 8);
        chk("skew.eq_pulses", eq_pulses, 8);
        chk("skew.overflow", bus.overflow, 0);
        chk("skew.mismatch", bus.mismatch, 0);

        // Masked bit: reg_dmiss differs but is not compared
        push2(1, INST13 | DMISS, 1, INST13);
        idle(3);
        chk("masked.count", bus.cmp_count, 9);
        chk("masked.eq_pulses", eq_pulses, 9);
        chk("masked.mismatch", bus.mismatch, 0);

        // Mismatch capture
        push2(1, INST13, 1, INST33);
        idle(2);
        chk("mis.cmp_valid", bus.cmp_valid, 1);
        chk("mis.cmp_equal", bus.cmp_equal, 0);
        chk("mis.mismatch", bus.mismatch, 1);
        chk("mis.diff_bits", bus.diff_bits, 35'h0_0000_0040);
        chk("mis.state", bus.state, 2);
        push2(1, '0, 1, 35'h7_FFFF_FFFF);
        idle(3);
        chk("mis2.diff_bits", bus.diff_bits, 35'h0_0000_0040);
        chk("mis2.count", bus.cmp_count, 10);
        chk("mis2.state", bus.state, 2);

        // Clear out of MISMATCH
        cyc(); bus.clear = 1; bus.enable = 0;
        cyc(); bus.clear = 0;
        cyc();
        check_zero("clear1");

        // Overflow: 5 pushes into A with nothing from B
        bus.enable = 1;
        cyc();
        for (int i = 0; i < 5; i++) push2(1, 35'(i + 1), 0, '0);
        idle(1);
        chk("ovf.overflow", bus.overflow, 1);
        chk("ovf.state", bus.state, 3);
        chk("ovf.mismatch", bus.mismatch, 0);
        cyc(); bus.clear = 1; bus.enable = 0;
        cyc(); bus.clear = 0;
        cyc();
        check_zero("clear2");

        // Randomized traffic; B mostly replays A's stream
        bus.enable = 1;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            reset = ($urandom_range(0, 299) == 0);
            bus.clear = ($urandom_range(0, 39) == 0);
            bus.enable = ($urandom_range(0, 19) != 0);
            bus.a_valid = ($urandom_range(0, 99) < 60);
            bus.a_snap = rnd35();
            if (bus.a_valid) pend.push_back(bus.a_snap);
            bus.b_valid = ($urandom_range(0, 99) < 50);
            if (bus.b_valid && pend.size() > 0 && $urandom_range(0, 29) != 0)
                bus.b_snap = pend.pop_front();
            else
                bus.b_snap = rnd35();
            if (reset || bus.clear) pend.delete();
        end
        reset = 0; bus.clear = 0; bus.a_valid = 0; bus.b_valid = 0;

        // Count saturation
        cyc(); reset = 1;
        cyc(); reset = 0; bus.enable = 1;
        cyc();
        for (int i = 0; i < 65540; i++) push2(1, INST13, 1, INST13);
        idle(3);
        chk("sat.count", bus.cmp_count, 16'hFFFF);
        chk("sat.state", bus.state, 1);
        chk("sat.mismatch", bus.mismatch, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
